// File: rtl/pipe_register.sv
// Multi-stage elastic pipeline register with per-stage valids, collapsing bubbles,
// global clock enable and synchronous flush. Define PIPE_REGISTER_COUNT_EN to build the occupancy counter.
module pipe_register #(
    parameter int                    WORD_WIDTH  = 32,
    parameter int                    DEPTH       = 2,
    parameter logic [WORD_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clk_en,
    input  logic                         flush,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [WORD_WIDTH-1:0]        i_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [WORD_WIDTH-1:0]        o_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    generate
        if (DEPTH < 1) begin : g_bad_depth
            $error("pipe_register: DEPTH must be at least 1");
        end
    endgenerate

    // Handshake: a word moves across a port on a rising edge exactly when valid and ready
    // are both high in the cycle before it; valid never waits on ready, and ready may
    // depend combinationally on the downstream ready of the same cycle.
    logic [DEPTH-1:0]      valid_q;
    logic [DEPTH-1:0]      adv;
    logic [DEPTH-1:0]      free;
    logic [WORD_WIDTH-1:0] data_q [DEPTH];

    // Ready ripples from the output back to stage 0: a stage is free when empty or draining.
    always_comb begin
        logic downstream_free;
        downstream_free = i_ready;
        adv  = '0;
        free = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            adv[k]          = valid_q[k] & downstream_free;
            free[k]         = ~valid_q[k] | adv[k];
            downstream_free = free[k];
        end
    end

    assign o_ready = clk_en & ~flush & free[0];
    assign o_valid = clk_en & valid_q[DEPTH-1];
    assign o_data  = data_q[DEPTH-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            for (int k = 0; k < DEPTH; k++) data_q[k] <= RESET_VALUE;
        end else if (flush) begin
            valid_q <= '0;
            for (int k = 0; k < DEPTH; k++) data_q[k] <= RESET_VALUE;
        end else if (clk_en) begin
            if (free[0]) begin
                valid_q[0] <= i_valid & o_ready;
                data_q[0]  <= i_data;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (free[k]) begin
                    valid_q[k] <= adv[k-1];
                    data_q[k]  <= data_q[k-1];
                end
            end
        end
    end

`ifdef PIPE_REGISTER_COUNT_EN
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] count_q;
    logic          in_xfer;
    logic          out_xfer;

    assign in_xfer  = i_valid & o_ready;
    assign out_xfer = o_valid & i_ready;

    // Tracks accepts minus deliveries; bounded by the stage count so it cannot wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (flush) begin
            count_q <= '0;
        end else if (clk_en) begin
            if (in_xfer & ~out_xfer) begin
                count_q <= count_q + 1'b1;
            end else if (out_xfer & ~in_xfer) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign o_count = count_q;
`else
    assign o_count = '0;
`endif

endmodule

// File: tb/tb_pipe_register.sv
// Self-checking bench for pipe_register: three instances (DEPTH 2, 3, 4) share stimulus,
// each scenario task checks one instance against a queue-based scoreboard.
module tb_pipe_register;

    localparam int         W  = 8;
    localparam logic [7:0] RV = 8'h5A;
`ifdef PIPE_REGISTER_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         clk_en = 1'b1;
    logic         flush = 1'b0;
    logic         i_valid = 1'b0;
    logic         i_ready = 1'b0;
    logic [W-1:0] i_data = '0;

    logic         o_ready2, o_valid2, o_ready3, o_valid3, o_ready4, o_valid4;
    logic [W-1:0] o_data2, o_data3, o_data4;
    logic [1:0]   o_count2, o_count3;
    logic [2:0]   o_count4;

    int           n_checks = 0;
    int           n_fail = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    pipe_register #(.WORD_WIDTH(W), .DEPTH(2), .RESET_VALUE(RV)) d2 (
        .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .flush(flush),
        .i_valid(i_valid), .o_ready(o_ready2), .i_data(i_data),
        .o_valid(o_valid2), .i_ready(i_ready), .o_data(o_data2), .o_count(o_count2)
    );

    pipe_register #(.WORD_WIDTH(W), .DEPTH(3), .RESET_VALUE(RV)) d3 (
        .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .flush(flush),
        .i_valid(i_valid), .o_ready(o_ready3), .i_data(i_data),
        .o_valid(o_valid3), .i_ready(i_ready), .o_data(o_data3), .o_count(o_count3)
    );

    pipe_register #(.WORD_WIDTH(W), .DEPTH(4), .RESET_VALUE(RV)) d4 (
        .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .flush(flush),
        .i_valid(i_valid), .o_ready(o_ready4), .i_data(i_data),
        .o_valid(o_valid4), .i_ready(i_ready), .o_data(o_data4), .o_count(o_count4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clk_en  = 1'b1;
        flush   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_data  = '0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 8'h11;
        tick();
        i_data  = 8'h22;
        tick();
        i_valid = 1'b0;
        tick();
        n_checks++;
        if (o_valid3 !== 1'b1 || o_data3 !== 8'h11) begin
            n_fail++;
            $display("FAIL reset_inflight: got valid=%0b data=%0h expected valid=1 data=11", o_valid3, o_data3);
        end
        n_checks++;
        if (o_count3 !== (CNT_EN ? 2'd2 : 2'd0)) begin
            n_fail++;
            $display("FAIL reset_inflight_count: got %0d expected %0d", o_count3, CNT_EN ? 2 : 0);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (o_valid3 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_o_valid: got %0b expected 0", o_valid3);
        end
        n_checks++;
        if (o_data3 !== RV) begin
            n_fail++;
            $display("FAIL reset_o_data: got %0h expected %0h", o_data3, RV);
        end
        n_checks++;
        if (o_count3 !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_o_count: got %0d expected 0", o_count3);
        end
        n_checks++;
        if (o_valid2 !== 1'b0 || o_data2 !== RV) begin
            n_fail++;
            $display("FAIL reset_d2: got valid=%0b data=%0h expected valid=0 data=%0h", o_valid2, o_data2, RV);
        end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_stream();
        int next, acc_c, first_out, last_out, outs;
        logic [W-1:0] exp;
        do_reset();
        i_ready   = 1'b1;
        next      = 1;
        acc_c     = -1;
        first_out = -1;
        last_out  = -1;
        outs      = 0;
        for (int c = 0; c < 30 && outs < 8; c++) begin
            i_valid = (next <= 8);
            i_data  = next[W-1:0];
            @(negedge clk);
            if (o_valid2 && i_ready) begin
                if (first_out < 0) begin
                    first_out = c;
                end else begin
                    n_checks++;
                    if (c != last_out + 1) begin
                        n_fail++;
                        $display("FAIL stream_gap: got output cycle %0d expected %0d", c, last_out + 1);
                    end
                end
                last_out = c;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stream_extra: got %0h expected no word", o_data2);
                end else begin
                    exp = exp_q.pop_front();
                    if (o_data2 !== exp) begin
                        n_fail++;
                        $display("FAIL stream_data: got %0h expected %0h", o_data2, exp);
                    end
                end
                outs++;
            end
            if (i_valid && o_ready2) begin
                exp_q.push_back(i_data);
                if (acc_c < 0) acc_c = c;
                next++;
            end
            tick();
        end
        i_valid = 1'b0;
        n_checks++;
        if (outs != 8) begin
            n_fail++;
            $display("FAIL stream_count: got %0d expected 8", outs);
        end
        n_checks++;
        if (first_out != acc_c + 2) begin
            n_fail++;
            $display("FAIL stream_latency: got first output cycle %0d expected %0d", first_out, acc_c + 2);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] words [4];
        logic [W-1:0] exp;
        int idx, outs;
        words = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
        do_reset();
        i_ready = 1'b0;
        idx     = 0;
        outs    = 0;
        for (int c = 0; c < 8; c++) begin
            i_valid = (idx < 4);
            i_data  = (idx < 4) ? words[idx] : 8'h00;
            @(negedge clk);
            if (o_valid3) begin
                n_checks++;
                if (o_data3 !== 8'h0A) begin
                    n_fail++;
                    $display("FAIL bp_hold: got %0h expected 0a", o_data3);
                end
            end
            if (i_valid && o_ready3) begin
                exp_q.push_back(i_data);
                idx++;
            end
            tick();
        end
        n_checks++;
        if (idx != 3) begin
            n_fail++;
            $display("FAIL bp_accepts: got %0d expected 3", idx);
        end
        n_checks++;
        if (o_ready3 !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ready_low: got %0b expected 0", o_ready3);
        end
        i_ready = 1'b1;
        for (int c = 0; c < 20 && outs < 4; c++) begin
            i_valid = (idx < 4);
            i_data  = (idx < 4) ? words[idx] : 8'h00;
            @(negedge clk);
            if (o_valid3 && i_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL bp_extra: got %0h expected no word", o_data3);
                end else begin
                    exp = exp_q.pop_front();
                    if (o_data3 !== exp) begin
                        n_fail++;
                        $display("FAIL bp_data: got %0h expected %0h", o_data3, exp);
                    end
                end
                outs++;
            end
            if (i_valid && o_ready3) begin
                exp_q.push_back(i_data);
                idx++;
            end
            tick();
        end
        i_valid = 1'b0;
        n_checks++;
        if (outs != 4 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_drain: got %0d delivered, %0d left expected 4 delivered, 0 left", outs, exp_q.size());
        end
    endtask

    task automatic test_clk_en();
        logic [W-1:0] exp;
        int outs;
        do_reset();
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 8'h31;
        exp_q.push_back(8'h31);
        tick();
        i_data  = 8'h32;
        exp_q.push_back(8'h32);
        tick();
        i_valid = 1'b0;
        tick();
        clk_en  = 1'b0;
        i_valid = 1'b1;
        i_data  = 8'hEE;
        i_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (o_valid3 !== 1'b0 || o_ready3 !== 1'b0) begin
                n_fail++;
                $display("FAIL ce_frozen_hs: got valid=%0b ready=%0b expected 0 0", o_valid3, o_ready3);
            end
            n_checks++;
            if (o_count3 !== (CNT_EN ? 2'd2 : 2'd0)) begin
                n_fail++;
                $display("FAIL ce_frozen_count: got %0d expected %0d", o_count3, CNT_EN ? 2 : 0);
            end
            tick();
        end
        clk_en  = 1'b1;
        i_valid = 1'b0;
        outs    = 0;
        for (int c = 0; c < 10 && outs < 2; c++) begin
            @(negedge clk);
            if (c == 0) begin
                n_checks++;
                if (o_valid3 !== 1'b1 || o_count3 !== (CNT_EN ? 2'd2 : 2'd0)) begin
                    n_fail++;
                    $display("FAIL ce_resume: got valid=%0b count=%0d expected valid=1 count=%0d", o_valid3, o_count3, CNT_EN ? 2 : 0);
                end
            end
            if (o_valid3 && i_ready) begin
                n_checks++;
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
                if (o_data3 !== exp) begin
                    n_fail++;
                    $display("FAIL ce_data: got %0h expected %0h", o_data3, exp);
                end
                outs++;
            end
            tick();
        end
        n_checks++;
        if (outs != 2) begin
            n_fail++;
            $display("FAIL ce_delivered: got %0d expected 2", outs);
        end
    endtask

    task automatic test_flush();
        logic [W-1:0] exp;
        int acc_c, out_c;
        bit sent;
        do_reset();
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 8'h41;
        tick();
        i_data  = 8'h42;
        tick();
        i_data  = 8'h43;
        tick();
        n_checks++;
        if (o_count3 !== (CNT_EN ? 2'd3 : 2'd0)) begin
            n_fail++;
            $display("FAIL flush_pre_count: got %0d expected %0d", o_count3, CNT_EN ? 3 : 0);
        end
        flush   = 1'b1;
        i_valid = 1'b1;
        i_data  = 8'hEE;
        @(negedge clk);
        n_checks++;
        if (o_ready3 !== 1'b0 || o_valid3 !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_cycle: got ready=%0b valid=%0b expected ready=0 valid=1", o_ready3, o_valid3);
        end
        tick();
        flush   = 1'b0;
        i_valid = 1'b0;
        n_checks++;
        if (o_valid3 !== 1'b0 || o_count3 !== 2'd0 || o_data3 !== RV) begin
            n_fail++;
            $display("FAIL flush_after: got valid=%0b count=%0d data=%0h expected 0 0 %0h", o_valid3, o_count3, o_data3, RV);
        end
        i_ready = 1'b1;
        sent    = 1'b0;
        acc_c   = -1;
        out_c   = -1;
        for (int c = 0; c < 12; c++) begin
            i_valid = !sent;
            i_data  = 8'h77;
            @(negedge clk);
            if (o_valid3 && i_ready) begin
                n_checks++;
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
                if (o_data3 !== exp) begin
                    n_fail++;
                    $display("FAIL flush_data: got %0h expected %0h", o_data3, exp);
                end
                if (out_c < 0) out_c = c;
            end
            if (i_valid && o_ready3) begin
                exp_q.push_back(i_data);
                acc_c = c;
                sent  = 1'b1;
            end
            tick();
        end
        i_valid = 1'b0;
        n_checks++;
        if (acc_c < 0 || out_c != acc_c + 3) begin
            n_fail++;
            $display("FAIL flush_latency: got output cycle %0d expected %0d", out_c, acc_c + 3);
        end
    endtask

    task automatic test_count();
        logic [W-1:0] exp;
        int occ;
        bit acc, del;
        do_reset();
        occ = 0;
        for (int c = 0; c < 1000; c++) begin
            clk_en  = ($urandom_range(0, 9) != 0);
            i_valid = $urandom_range(0, 1);
            i_ready = $urandom_range(0, 1);
            i_data  = $urandom_range(0, 255);
            @(negedge clk);
            n_checks++;
            if (o_count4 !== (CNT_EN ? occ[2:0] : 3'd0) || o_count4 > 3'd4) begin
                n_fail++;
                $display("FAIL count_value: cycle %0d got %0d expected %0d", c, o_count4, CNT_EN ? occ : 0);
            end
            n_checks++;
            if (o_ready4 !== (clk_en && (occ < 4 || i_ready))) begin
                n_fail++;
                $display("FAIL count_ready: cycle %0d got %0b expected %0b", c, o_ready4, clk_en && (occ < 4 || i_ready));
            end
            del = o_valid4 && i_ready;
            acc = i_valid && o_ready4;
            if (del) begin
                n_checks++;
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
                if (o_data4 !== exp) begin
                    n_fail++;
                    $display("FAIL count_data: cycle %0d got %0h expected %0h", c, o_data4, exp);
                end
            end
            if (acc) exp_q.push_back(i_data);
            if (del && !acc) occ--;
            else if (acc && !del) occ++;
            tick();
        end
        clk_en  = 1'b1;
        i_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_clk_en();
        test_flush();
        test_count();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
